// File: rtl/gameplay_datapath.sv
// Gameplay datapath: moving block position/direction, previous row, row index,
// score and chances, updated by single-cycle control strobes from the FSM.
module gameplay_datapath #(
  parameter int SCREEN_W     = 160,
  parameter int BLOCK_W      = 16,
  parameter int ROW_H        = 8,
  parameter int Y_BASE       = 112,
  parameter int MAX_ROWS     = 15,
  parameter int SHIFT_DIV    = 4,
  parameter int INIT_CHANCES = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic       ld_d,
  input  logic       enable,
  input  logic       save_x,
  input  logic       inc_row,
  input  logic       inc_score,
  input  logic       dec_chances,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] prev_x,
  output logic [3:0] row,
  output logic [7:0] score,
  output logic [3:0] chances,
  output logic       c,
  output logic       o
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - BLOCK_W);
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  logic          dir;  // 1 = moving right
  logic [DW-1:0] div;
  logic [3:0]    row_next;
  logic          tick;
  logic [7:0]    x_start;
  logic [7:0]    x_shift;
  logic          turn;
  logic [6:0]    y_calc;
  logic [8:0]    diff;
  logic [8:0]    adiff;

  always_comb begin
    row_next = row;
    if (inc_row && (row < 4'(MAX_ROWS - 1))) row_next = row + 4'd1;
  end

  assign tick    = enable && !ld_x && (div == DIV_LAST);
  assign x_start = row_next[0] ? X_MAX : 8'd0;
  // Row start y, wrapped to the 7-bit output; parameters keep it non-negative.
  assign y_calc  = 7'(Y_BASE) - 7'(ROW_H) * {3'b000, row_next};

  // Bounce at the edges: the turning move already steps one pixel back inward.
  always_comb begin
    turn    = 1'b0;
    x_shift = x;
    if (dir) begin
      if (x == X_MAX) begin
        turn    = 1'b1;
        x_shift = x - 8'd1;
      end else begin
        x_shift = x + 8'd1;
      end
    end else begin
      if (x == 8'd0) begin
        turn    = 1'b1;
        x_shift = 8'd1;
      end else begin
        x_shift = x - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x       <= 8'd0;
      y       <= 7'(Y_BASE);
      dir     <= 1'b1;
      prev_x  <= 8'd0;
      row     <= 4'd0;
      score   <= 8'd0;
      chances <= 4'(INIT_CHANCES);
      div     <= '0;
    end else begin
      if (!enable || ld_x || tick) div <= '0;
      else                         div <= div + 1'b1;

      if (ld_x)      x <= x_start;
      else if (tick) x <= x_shift;

      if (ld_d)              dir <= ~row_next[0];
      else if (tick && turn) dir <= ~dir;

      if (ld_y)   y      <= y_calc;
      if (save_x) prev_x <= x;
      row <= row_next;

      if (inc_score && (score != 8'hFF))  score   <= score + 8'd1;
      if (dec_chances && (chances != 4'd0)) chances <= chances - 4'd1;
    end
  end

  assign c     = (chances != 4'd0);
  assign diff  = {1'b0, x} - {1'b0, prev_x};
  assign adiff = diff[8] ? (~diff + 9'd1) : diff;
  assign o     = (adiff < 9'(BLOCK_W));

endmodule
